// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer.
package muldiv_pkg;

    localparam int MD_ITERS = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } mdOp_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ITER = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } mdState_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add for multiply, restoring trial subtract for divide.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  mdOp_t            op,
    input  logic [WIDTH-1:0] accHi,
    input  logic [WIDTH-1:0] accLo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] nextHi,
    output logic [WIDTH-1:0] nextLo
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    always_comb begin
        sum     = {1'b0, accHi} + {1'b0, operand};
        shifted = {accHi, accLo[WIDTH-1]};
        diff    = shifted[WIDTH-1:0] - operand;
        nextHi  = accHi;
        nextLo  = accLo;
        if (op[1]) begin
            // Remainder always fits WIDTH bits because it stays below the divisor.
            if (shifted >= {1'b0, operand}) begin
                nextHi = diff;
                nextLo = {accLo[WIDTH-2:0], 1'b1};
            end else begin
                nextHi = shifted[WIDTH-1:0];
                nextLo = {accLo[WIDTH-2:0], 1'b0};
            end
        end else if (accLo[0]) begin
            nextHi = sum[WIDTH:1];
            nextLo = {sum[0], accLo[WIDTH-1:1]};
        end else begin
            nextHi = {1'b0, accHi[WIDTH-1:1]};
            nextLo = {accHi[0], accLo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO owner and 32-step multiply/divide sequencer; MULDIV_EARLY_OUT_EN enables multiply early exit.
//   state  | meaning
//   S_IDLE | waiting for StartE, mthi/mtlo accepted
//   S_ITER | one shift-add / trial-subtract step per cycle
//   S_FIX  | sign correction, HI/LO written
//   S_DONE | DoneE pulse, back-to-back start accepted
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITERS = MD_ITERS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StartE,
    input  logic [1:0]       MulDivOpE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             HiWE,
    input  logic             LoWE,
    input  logic [WIDTH-1:0] WriteDataE,
    output logic             BusyE,
    output logic             DoneE,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut
);

    localparam int CW = $clog2(ITERS);

    mdState_t state, nextState;
    mdOp_t    op;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] operand, accHi, accLo, stepHi, stepLo;
    logic [WIDTH-1:0] hiReg, loReg, fixHi, fixLo, aMag, bMag;
    logic [2*WIDTH-1:0] prod;
    logic negRes, negDvd, divZero;
    logic aNeg, bNeg, accept, lastStep, earlyOut;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .op      (op),
        .accHi   (accHi),
        .accLo   (accLo),
        .operand (operand),
        .nextHi  (stepHi),
        .nextLo  (stepLo)
    );

    always_comb begin
        aNeg = ~MulDivOpE[0] & SrcAE[WIDTH-1];
        bNeg = ~MulDivOpE[0] & SrcBE[WIDTH-1];
        aMag = aNeg ? -SrcAE : SrcAE;
        bMag = bNeg ? -SrcBE : SrcBE;
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic [WIDTH-1:0] remMask;
    // Multiplier bits not yet consumed sit in the low end of accLo.
    assign remMask  = {WIDTH{1'b1}} >> ({1'b0, cnt} + (CW+1)'(1));
    assign earlyOut = !op[1] && (((accLo >> 1) & remMask) == '0);
`else
    assign earlyOut = 1'b0;
`endif

    assign lastStep = (cnt == CW'(ITERS-1)) || earlyOut;

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        BusyE     = 1'b0;
        DoneE     = 1'b0;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                accept = StartE;
                if (StartE) nextState = S_ITER;
            end
            S_ITER: begin
                BusyE = 1'b1;
                if (lastStep) nextState = S_FIX;
            end
            S_FIX: begin
                BusyE     = 1'b1;
                nextState = S_DONE;
            end
            S_DONE: begin
                DoneE     = 1'b1;
                accept    = StartE;
                nextState = StartE ? S_ITER : S_IDLE;
            end
            default: nextState = S_IDLE;
        endcase
    end

    always_comb begin
        prod = {accHi, accLo};
`ifdef MULDIV_EARLY_OUT_EN
        // Align a product that left ITER before all steps were shifted in.
        prod = prod >> (CW'(ITERS-1) - cnt);
`endif
        if (negRes) prod = -prod;
        if (op[1]) begin
            fixLo = divZero ? {WIDTH{1'b1}} : (negRes ? -accLo : accLo);
            fixHi = negDvd ? -accHi : accHi;
        end else begin
            fixHi = prod[2*WIDTH-1:WIDTH];
            fixLo = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            op      <= MD_MULT;
            cnt     <= '0;
            operand <= '0;
            accHi   <= '0;
            accLo   <= '0;
            negRes  <= 1'b0;
            negDvd  <= 1'b0;
            divZero <= 1'b0;
            hiReg   <= '0;
            loReg   <= '0;
        end else begin
            if (accept) begin
                op      <= mdOp_t'(MulDivOpE);
                cnt     <= '0;
                operand <= MulDivOpE[1] ? bMag : aMag;
                accHi   <= '0;
                accLo   <= MulDivOpE[1] ? aMag : bMag;
                negRes  <= aNeg ^ bNeg;
                negDvd  <= aNeg;
                divZero <= MulDivOpE[1] && (SrcBE == '0);
            end else if (state == S_ITER) begin
                accHi <= stepHi;
                accLo <= stepLo;
                if (!lastStep) cnt <= cnt + CW'(1);
            end
            if (state == S_FIX) begin
                hiReg <= fixHi;
                loReg <= fixLo;
            end else if (!BusyE) begin
                if (HiWE) hiReg <= WriteDataE;
                if (LoWE) loReg <= WriteDataE;
            end
        end
    end

    assign HiOut = hiReg;
    assign LoOut = loReg;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed ops, back-to-back starts, reset, mthi/mtlo.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        StartE = 1'b0;
    logic [1:0]  MulDivOpE = 2'b00;
    logic [31:0] SrcAE = '0, SrcBE = '0, WriteDataE = '0;
    logic        HiWE = 1'b0, LoWE = 1'b0;
    logic        BusyE, DoneE;
    logic [31:0] HiOut, LoOut;

    muldiv_sequencer #(.WIDTH(32), .ITERS(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .StartE     (StartE),
        .MulDivOpE  (MulDivOpE),
        .SrcAE      (SrcAE),
        .SrcBE      (SrcBE),
        .HiWE       (HiWE),
        .LoWE       (LoWE),
        .WriteDataE (WriteDataE),
        .BusyE      (BusyE),
        .DoneE      (DoneE),
        .HiOut      (HiOut),
        .LoOut      (LoOut)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        int          startCyc;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
        int          early;
    } vec_t;
    vec_t vecs [0:8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare every DoneE pulse against the oldest expectation.
    int busyCnt = 0;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset) begin
            busyCnt = 0;
        end else begin
            if (BusyE) busyCnt++;
            if (DoneE) begin
                if (sbq.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sbq.pop_front();
                    check("hi", {32'd0, HiOut}, {32'd0, e.hi});
                    check("lo", {32'd0, LoOut}, {32'd0, e.lo});
                    check("latency", 64'(cyc - e.startCyc), 64'(e.lat));
                    check("busy_cycles", 64'(busyCnt), 64'(e.lat));
                end
                busyCnt = 0;
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hi, input logic [31:0] lo, input int lat);
        exp_t e;
        MulDivOpE = op;
        SrcAE     = a;
        SrcBE     = b;
        StartE    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        StartE     = 1'b0;
        SrcAE      = 32'hDEAD_BEEF;
        SrcBE      = 32'h0BAD_F00D;
        e.hi       = hi;
        e.lo       = lo;
        e.lat      = lat;
        e.startCyc = cyc;
        sbq.push_back(e);
    endtask

    task automatic waitDone();
        int n = 0;
        while (!DoneE && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33};
        vecs[1] = '{MD_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 4};
        vecs[2] = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
        vecs[3] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33};
        vecs[4] = '{MD_DIVU,  32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 33};
        vecs[5] = '{MD_MULTU, 32'h0000_0005, 32'h0000_0001, 32'h0000_0000, 32'h0000_0005, 2};
        vecs[6] = '{MD_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 33};
        vecs[7] = '{MD_MULT,  32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 33};
        vecs[8] = '{MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33};

        repeat (3) @(negedge clk);
        check("reset_busy", 64'(BusyE), 64'd0);
        check("reset_done", 64'(DoneE), 64'd0);
        check("reset_hi", 64'(HiOut), 64'd0);
        check("reset_lo", 64'(LoOut), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Directed vectors, each started in the DONE cycle of the previous one.
        for (int i = 0; i < 9; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
                  EARLY ? vecs[i].early : 33);
            waitDone();
        end
        @(negedge clk);

        // Start and register writes while busy are ignored.
        issue(MD_DIVU, 32'd1000, 32'd10, 32'd0, 32'd100, 33);
        repeat (3) @(negedge clk);
        MulDivOpE  = MD_MULTU;
        SrcAE      = 32'd2;
        SrcBE      = 32'd2;
        StartE     = 1'b1;
        HiWE       = 1'b1;
        LoWE       = 1'b1;
        WriteDataE = 32'hDEAD_0000;
        @(negedge clk);
        StartE = 1'b0;
        HiWE   = 1'b0;
        LoWE   = 1'b0;
        check("busy_hi_write", 64'(HiOut), 64'h1);
        check("busy_lo_write", 64'(LoOut), 64'hFFFF_FFFD);
        waitDone();
        repeat (40) @(negedge clk);
        check("idle_after_ignored_start", 64'(BusyE), 64'd0);

        // Register write in the same cycle as a start: write lands first.
        HiWE       = 1'b1;
        WriteDataE = 32'h5555_5555;
        issue(MD_MULTU, 32'h0001_0001, 32'h0007_0000, 32'h0000_0007, 32'h0007_0000,
              EARLY ? 20 : 33);
        HiWE = 1'b0;
        check("write_with_start", 64'(HiOut), 64'h5555_5555);
        waitDone();
        @(negedge clk);

        // Reset in the middle of an operation.
        MulDivOpE = MD_MULTU;
        SrcAE     = 32'hFFFF_FFFF;
        SrcBE     = 32'hFFFF_FFFF;
        StartE    = 1'b1;
        @(negedge clk);
        StartE = 1'b0;
        repeat (10) @(negedge clk);
        check("busy_mid_op", 64'(BusyE), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        check("midreset_busy", 64'(BusyE), 64'd0);
        check("midreset_done", 64'(DoneE), 64'd0);
        check("midreset_hi", 64'(HiOut), 64'd0);
        check("midreset_lo", 64'(LoOut), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        HiWE       = 1'b1;
        WriteDataE = 32'h0000_ABCD;
        @(negedge clk);
        HiWE = 1'b0;
        check("mthi", 64'(HiOut), 64'h0000_ABCD);
        check("mthi_lo_untouched", 64'(LoOut), 64'd0);
        LoWE       = 1'b1;
        WriteDataE = 32'h0000_1357;
        @(negedge clk);
        LoWE = 1'b0;
        check("mtlo", 64'(LoOut), 64'h0000_1357);
        check("mtlo_hi_untouched", 64'(HiOut), 64'h0000_ABCD);

        repeat (40) @(negedge clk);
        check("scoreboard_drained", 64'(sbq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multiply/divide controller sitting beside the EX-stage ALU. Sequences 32 shift-add (multiply) or restoring trial-subtract (divide) steps and owns the HI/LO architectural registers.
- Drives a busy flag that the hazard unit uses to stall the pipeline. Handles mult, multu, div, divu, mthi and mtlo; mfhi/mflo read HiOut/LoOut directly.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- ITERS, 32, iteration count; must equal WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
- StartE  input  1  start request from the EX stage.
- MulDivOpE  input  2  00 mult, 01 multu, 10 div, 11 divu.
- SrcAE  input  WIDTH  multiplicand / dividend.
- SrcBE  input  WIDTH  multiplier / divisor.
- HiWE  input  1  mthi write enable.
- LoWE  input  1  mtlo write enable.
- WriteDataE  input  WIDTH  mthi/mtlo data.
- BusyE  output  1  operation in progress; pipeline stall request.
- DoneE  output  1  single-cycle completion pulse.
- HiOut  output  WIDTH  HI register.
- LoOut  output  WIDTH  LO register.

Behaviour:
- Reset (reset=0 at an edge), from any state including mid-operation:
  - state goes to IDLE; HiOut=0, LoOut=0, BusyE=0, DoneE=0; internal accumulators cleared.
- States and transitions: IDLE, ITER, FIX, DONE.
  - IDLE/DONE with StartE=1: latch op; latch operand magnitudes (signed ops take abs, record result sign and dividend sign); counter=0; go to ITER. DONE without start returns to IDLE.
  - ITER: one step per cycle; counter increments; after step ITERS (counter==ITERS-1) go to FIX.
  - FIX: apply sign correction, write HI/LO, go to DONE.
  - DONE: DoneE=1 for exactly this cycle.
- Timing and outputs:
  - BusyE=1 exactly while in ITER or FIX.
  - Latency: start sampled at edge k, HI/LO updated at edge k+33, DoneE high during cycle k+33.
  - Back-to-back: a start sampled in DONE is accepted with no gap.
- Multiply:
  - 2*WIDTH product is formed from magnitudes by shift-add.
  - Signed ops negate the full 64-bit product when operand signs differ.
  - HI = upper word, LO = lower word.
- Divide:
  - Restoring division on magnitudes gives quotient to LO and remainder to HI.
  - Signed: quotient negated if signs differ; remainder takes the dividend's sign.
  - 0x80000000 / -1 (signed) gives LO=0x80000000, HI=0.
- Divide by zero (div or divu): LO=0xFFFFFFFF, HI=original SrcAE. Still takes the full 33 cycles.
- mthi/mtlo:
  - HiWE/LoWE take effect at the next edge when not busy.
  - Ignored while BusyE=1.
  - A write and a start in the same cycle: the write is applied, then the FIX write overwrites it.
- StartE while BusyE=1 is ignored; no queuing.
- MulDivOpE/SrcAE/SrcBE are only sampled on the accepting edge; changes during ITER have no effect.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: during multiply ITER, if the remaining shifted multiplier bits are all zero, go to FIX immediately. Latency shrinks to (index of highest set bit of |SrcB|)+2 cycles, minimum 2 for a zero multiplier. Divide is unchanged.
- Undefined: fixed 33-cycle latency for all ops.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encodings MD_MULT/MD_MULTU/MD_DIV/MD_DIVU;
  - state encoding S_IDLE/S_ITER/S_FIX/S_DONE;
  - constant MD_ITERS=32.
- One sub-module, muldiv_step: combinational single iteration.
  - Multiply mode: conditional add and shift.
  - Divide mode: trial subtract, restore and shift in the quotient bit.
  - Instantiated once and driven by the FSM.

Test Plan:
- Unsigned multiply: multu 0xFFFFFFFF x 0xFFFFFFFF -> BusyE=1 for 33 cycles, HI=0xFFFFFFFE, LO=0x00000001, one DoneE pulse.
- Signed multiply: mult -3 x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- Signed divide, negative dividend: div -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Signed overflow: div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero: divu 0x1234 / 0 -> LO=0xFFFFFFFF, HI=0x1234.
- Reset and register writes:
  - Assert reset=0 at iteration 10 of multu -> next cycle BusyE=0, HI=LO=0.
  - After reset, mthi 0xABCD -> HiOut=0xABCD next cycle.
  - A start asserted while busy is ignored.
  - With MULDIV_EARLY_OUT_EN defined, multu 5 x 1 completes with DoneE 2 cycles after the start edge.
